// File: rtl/counter_ctrl_pkg.sv
// Shared types and constants for the counter sweep controller.
package counter_ctrl_pkg;

   localparam int unsigned DEF_NBITS_COUNT = 4;
   localparam int unsigned DEF_NBITS_PRESC = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_RUN  = 2'd2,
      ST_DONE = 2'd3
   } state_e;

   localparam logic [1:0] OP_NOP  = 2'b00;
   localparam logic [1:0] OP_LOAD = 2'b01;
   localparam logic [1:0] OP_INC  = 2'b10;
   localparam logic [1:0] OP_DEC  = 2'b11;

endpackage

// File: rtl/step_prescaler.sv
// Down-counting step prescaler: ticks when the count is zero, then reloads.
module step_prescaler #(
   parameter int unsigned NBITS_PRESC = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [NBITS_PRESC-1:0] presc,
   input  logic                   clear,
   input  logic                   enable,
   output logic                   tick_c
);

   logic [NBITS_PRESC-1:0] pc_q;
   logic [NBITS_PRESC-1:0] pc_d;

   // Tick is a pure function of the current count so it never loops back through clear.
   assign tick_c = enable && (pc_q == '0);

   // Next count: reload on clear or after a tick, otherwise count down while enabled.
   always_comb begin
      pc_d = pc_q;
      if (clear) begin
         pc_d = presc;
      end else if (enable) begin
         if (pc_q == '0) begin
            pc_d = presc;
         end else begin
            pc_d = pc_q - NBITS_PRESC'(1);
         end
      end
   end

   // Count register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         pc_q <= '0;
      end else begin
         pc_q <= pc_d;
      end
   end

endmodule

// File: rtl/counter_sweep_ctrl.sv
// Sweep controller for the up/down counter, with manual command arbitration.
module counter_sweep_ctrl
   import counter_ctrl_pkg::*;
#(
   parameter int unsigned NBITS_COUNT = DEF_NBITS_COUNT,
   parameter int unsigned NBITS_PRESC = DEF_NBITS_PRESC
) (
   input  logic                   clk_2,
   input  logic                   reset,
   input  logic                   start,
   input  logic                   stop,
   input  logic                   bounce,
   input  logic [NBITS_COUNT-1:0] lo_bound,
   input  logic [NBITS_COUNT-1:0] hi_bound,
   input  logic [NBITS_PRESC-1:0] presc,
   input  logic                   man_req,
   input  logic [1:0]             man_op,
   input  logic [NBITS_COUNT-1:0] man_data,
   output logic                   man_ack,
   output logic                   load,
   output logic [NBITS_COUNT-1:0] cnt_data,
   output logic                   counter_on,
   output logic                   count_up,
   output logic [NBITS_COUNT-1:0] pos,
   output logic                   busy,
   output logic                   done,
   output logic                   err
);

   state_e                 state_q, state_d;
   logic                   load_q, load_d;
   logic [NBITS_COUNT-1:0] cnt_data_q, cnt_data_d;
   logic                   counter_on_q, counter_on_d;
   logic                   count_up_q, count_up_d;
   logic [NBITS_COUNT-1:0] pos_q, pos_d;
   logic                   dir_q, dir_d;
   logic                   man_ack_q, man_ack_d;
   logic                   busy_q, busy_d;
   logic                   done_q, done_d;
   logic                   err_q, err_d;
   logic                   step_c, step_up_c;
   logic                   tick_c;
   logic                   presc_clear_c, presc_en_c;

   // Prescaler is reloaded during the LOAD cycle and runs only in RUN.
   assign presc_clear_c = (state_q == ST_LOAD);
   assign presc_en_c    = (state_q == ST_RUN);

   step_prescaler #(
      .NBITS_PRESC(NBITS_PRESC)
   ) u_presc (
      .clk    (clk_2),
      .reset  (reset),
      .presc  (presc),
      .clear  (presc_clear_c),
      .enable (presc_en_c),
      .tick_c (tick_c)
   );

   // Next-state and registered-output decode.
   always_comb begin
      state_d      = state_q;
      load_d       = 1'b0;
      cnt_data_d   = cnt_data_q;
      counter_on_d = 1'b0;
      count_up_d   = 1'b0;
      pos_d        = pos_q;
      dir_d        = dir_q;
      man_ack_d    = 1'b0;
      err_d        = err_q;
      step_c       = 1'b0;
      step_up_c    = 1'b0;

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (stop) begin
               state_d = ST_IDLE;
            end else if (start) begin
               if (lo_bound > hi_bound) begin
                  state_d = ST_DONE;
                  err_d   = 1'b1;
               end else begin
                  state_d    = ST_LOAD;
                  err_d      = 1'b0;
                  load_d     = 1'b1;
                  cnt_data_d = lo_bound;
                  pos_d      = lo_bound;
                  dir_d      = 1'b1;
               end
            end else if (man_req) begin
               man_ack_d = 1'b1;
               case (man_op)
                  OP_LOAD: begin
                     load_d     = 1'b1;
                     cnt_data_d = man_data;
                     pos_d      = man_data;
                  end
                  OP_INC: begin
                     step_c    = 1'b1;
                     step_up_c = 1'b1;
                  end
                  OP_DEC: begin
                     step_c    = 1'b1;
                     step_up_c = 1'b0;
                  end
                  default: ;
               endcase
            end
         end
         ST_LOAD: begin
            state_d = ST_RUN;
         end
         ST_RUN: begin
            if (stop) begin
               state_d = ST_IDLE;
            end else if (tick_c) begin
               if (dir_q) begin
                  if (pos_q < hi_bound) begin
                     step_c    = 1'b1;
                     step_up_c = 1'b1;
                  end else if (bounce && (hi_bound > lo_bound)) begin
                     dir_d     = 1'b0;
                     step_c    = 1'b1;
                     step_up_c = 1'b0;
                  end else if (!bounce) begin
                     state_d = ST_DONE;
                  end
               end else begin
                  if (pos_q > lo_bound) begin
                     step_c    = 1'b1;
                     step_up_c = 1'b0;
                  end else begin
                     dir_d     = 1'b1;
                     step_c    = 1'b1;
                     step_up_c = 1'b1;
                  end
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // A step strobe moves the shadow position together with the counter.
      if (step_c) begin
         counter_on_d = 1'b1;
         count_up_d   = step_up_c;
         pos_d        = step_up_c ? (pos_q + NBITS_COUNT'(1)) : (pos_q - NBITS_COUNT'(1));
      end

      busy_d = (state_d == ST_LOAD) || (state_d == ST_RUN);
      done_d = (state_d == ST_DONE);
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk_2) begin
      if (!reset) begin
         state_q      <= ST_IDLE;
         load_q       <= 1'b0;
         cnt_data_q   <= '0;
         counter_on_q <= 1'b0;
         count_up_q   <= 1'b0;
         pos_q        <= '0;
         dir_q        <= 1'b1;
         man_ack_q    <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         load_q       <= load_d;
         cnt_data_q   <= cnt_data_d;
         counter_on_q <= counter_on_d;
         count_up_q   <= count_up_d;
         pos_q        <= pos_d;
         dir_q        <= dir_d;
         man_ack_q    <= man_ack_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         err_q        <= err_d;
      end
   end

   assign man_ack    = man_ack_q;
   assign load       = load_q;
   assign cnt_data   = cnt_data_q;
   assign counter_on = counter_on_q;
   assign count_up   = count_up_q;
   assign pos        = pos_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign err        = err_q;

endmodule

// File: tb/tb_counter_sweep_ctrl.sv
// Directed self-checking bench for counter_sweep_ctrl.
module tb_counter_sweep_ctrl;

   logic       clk_2 = 1'b0;
   logic       reset;
   logic       start;
   logic       stop;
   logic       bounce;
   logic [3:0] lo_bound;
   logic [3:0] hi_bound;
   logic [7:0] presc;
   logic       man_req;
   logic [1:0] man_op;
   logic [3:0] man_data;
   logic       man_ack;
   logic       load;
   logic [3:0] cnt_data;
   logic       counter_on;
   logic       count_up;
   logic [3:0] pos;
   logic       busy;
   logic       done;
   logic       err;

   int checks   = 0;
   int failures = 0;

   counter_sweep_ctrl dut (
      .clk_2      (clk_2),
      .reset      (reset),
      .start      (start),
      .stop       (stop),
      .bounce     (bounce),
      .lo_bound   (lo_bound),
      .hi_bound   (hi_bound),
      .presc      (presc),
      .man_req    (man_req),
      .man_op     (man_op),
      .man_data   (man_data),
      .man_ack    (man_ack),
      .load       (load),
      .cnt_data   (cnt_data),
      .counter_on (counter_on),
      .count_up   (count_up),
      .pos        (pos),
      .busy       (busy),
      .done       (done),
      .err        (err)
   );

   always #5 clk_2 = ~clk_2;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one clock and settle just after the edge.
   task automatic step();
      @(posedge clk_2);
      #1;
   endtask

   task automatic check_idle_outputs(input string tag);
      check_val({tag, " load"}, 32'(load), 32'd0);
      check_val({tag, " counter_on"}, 32'(counter_on), 32'd0);
      check_val({tag, " man_ack"}, 32'(man_ack), 32'd0);
   endtask

   logic [3:0] sw_pos[6]  = '{4'd2, 4'd3, 4'd2, 4'd1, 4'd2, 4'd3};
   logic       sw_dir[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

   initial begin
      int strobes;
      int idx;
      bit seen;

      reset = 1'b0; start = 1'b0; stop = 1'b0; bounce = 1'b0;
      lo_bound = '0; hi_bound = '0; presc = '0;
      man_req = 1'b0; man_op = 2'b00; man_data = '0;
      step();
      step();

      // Reset state
      check_val("rst load", 32'(load), 32'd0);
      check_val("rst counter_on", 32'(counter_on), 32'd0);
      check_val("rst count_up", 32'(count_up), 32'd0);
      check_val("rst man_ack", 32'(man_ack), 32'd0);
      check_val("rst busy", 32'(busy), 32'd0);
      check_val("rst done", 32'(done), 32'd0);
      check_val("rst err", 32'(err), 32'd0);
      check_val("rst cnt_data", 32'(cnt_data), 32'd0);
      check_val("rst pos", 32'(pos), 32'd0);
      reset = 1'b1;
      step();

      // Single up-sweep 2..5, presc 0
      lo_bound = 4'd2; hi_bound = 4'd5; presc = 8'd0; bounce = 1'b0;
      start = 1'b1;
      step();
      start = 1'b0;
      check_val("s1 load", 32'(load), 32'd1);
      check_val("s1 cnt_data", 32'(cnt_data), 32'd2);
      check_val("s1 pos", 32'(pos), 32'd2);
      check_val("s1 busy", 32'(busy), 32'd1);
      step();
      check_idle_outputs("s1 run_entry");
      for (int i = 0; i < 3; i++) begin
         step();
         check_val("s1 strobe", 32'(counter_on), 32'd1);
         check_val("s1 dir", 32'(count_up), 32'd1);
         check_val("s1 pos", 32'(pos), 32'(3 + i));
      end
      step();
      check_val("s1 done", 32'(done), 32'd1);
      check_val("s1 busy_end", 32'(busy), 32'd0);
      check_val("s1 no_strobe", 32'(counter_on), 32'd0);
      step();
      step();
      check_val("s1 still_no_strobe", 32'(counter_on), 32'd0);
      check_val("s1 pos_final", 32'(pos), 32'd5);

      // Ping-pong 1..3, presc 1
      lo_bound = 4'd1; hi_bound = 4'd3; presc = 8'd1; bounce = 1'b1;
      start = 1'b1;
      step();
      start = 1'b0;
      check_val("s2 load", 32'(load), 32'd1);
      check_val("s2 done_cleared", 32'(done), 32'd0);
      for (int k = 1; k <= 13; k++) begin
         step();
         if (k >= 3 && (k % 2) == 1) begin
            idx = (k - 3) / 2;
            check_val("s2 strobe", 32'(counter_on), 32'd1);
            check_val("s2 dir", 32'(count_up), 32'(sw_dir[idx]));
            check_val("s2 pos", 32'(pos), 32'(sw_pos[idx]));
         end else begin
            check_val("s2 gap", 32'(counter_on), 32'd0);
         end
      end
      step();
      check_val("s2 gap14", 32'(counter_on), 32'd0);
      stop = 1'b1;
      step();
      stop = 1'b0;
      check_val("s2 stop_strobe", 32'(counter_on), 32'd0);
      check_val("s2 stop_busy", 32'(busy), 32'd0);
      check_val("s2 stop_done", 32'(done), 32'd0);
      step();
      step();
      check_val("s2 pos_frozen", 32'(pos), 32'd3);
      check_val("s2 idle_strobe", 32'(counter_on), 32'd0);

      // Inverted bounds rejected, then a valid start clears err
      lo_bound = 4'd6; hi_bound = 4'd4; bounce = 1'b0; presc = 8'd0;
      start = 1'b1;
      step();
      start = 1'b0;
      check_val("s3 done", 32'(done), 32'd1);
      check_val("s3 err", 32'(err), 32'd1);
      check_val("s3 load", 32'(load), 32'd0);
      check_val("s3 busy", 32'(busy), 32'd0);
      step();
      check_val("s3 load_later", 32'(load), 32'd0);
      check_val("s3 err_held", 32'(err), 32'd1);
      lo_bound = 4'd4; hi_bound = 4'd6;
      start = 1'b1;
      step();
      start = 1'b0;
      check_val("s3 err_clear", 32'(err), 32'd0);
      check_val("s3 load_ok", 32'(load), 32'd1);
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         step();
         if (done) seen = 1'b1;
      end
      check_val("s3 reached_done", 32'(seen), 32'd1);
      check_val("s3 pos_end", 32'(pos), 32'd6);

      // lo == hi, no bounce: one load, no steps
      lo_bound = 4'd7; hi_bound = 4'd7; bounce = 1'b0;
      start = 1'b1;
      step();
      start = 1'b0;
      check_val("s4 load", 32'(load), 32'd1);
      check_val("s4 cnt_data", 32'(cnt_data), 32'd7);
      strobes = 0;
      for (int i = 0; i < 4; i++) begin
         step();
         strobes += int'(counter_on) + int'(load);
      end
      check_val("s4 strobes", 32'(strobes), 32'd0);
      check_val("s4 done", 32'(done), 32'd1);
      check_val("s4 pos", 32'(pos), 32'd7);

      // Manual request held off during RUN, served after stop
      lo_bound = 4'd0; hi_bound = 4'd15; presc = 8'd3; bounce = 1'b1;
      start = 1'b1;
      step();
      start = 1'b0;
      man_req = 1'b1; man_op = 2'b01; man_data = 4'd9;
      strobes = 0;
      for (int i = 0; i < 6; i++) begin
         step();
         strobes += int'(man_ack);
      end
      check_val("s5 no_ack_run", 32'(strobes), 32'd0);
      stop = 1'b1;
      step();
      stop = 1'b0;
      check_val("s5 no_ack_stop", 32'(man_ack), 32'd0);
      check_val("s5 idle", 32'(busy), 32'd0);
      step();
      man_req = 1'b0;
      check_val("s5 ack", 32'(man_ack), 32'd1);
      check_val("s5 load", 32'(load), 32'd1);
      check_val("s5 cnt_data", 32'(cnt_data), 32'd9);
      check_val("s5 pos", 32'(pos), 32'd9);
      step();
      check_idle_outputs("s5 after_ack");
      man_req = 1'b1; man_op = 2'b01; man_data = 4'hF;
      step();
      man_req = 1'b0;
      check_val("s5 pos_f", 32'(pos), 32'd15);
      step();
      man_req = 1'b1; man_op = 2'b10;
      step();
      man_req = 1'b0;
      check_val("s5 inc_ack", 32'(man_ack), 32'd1);
      check_val("s5 inc_on", 32'(counter_on), 32'd1);
      check_val("s5 inc_up", 32'(count_up), 32'd1);
      check_val("s5 inc_wrap", 32'(pos), 32'd0);
      step();
      man_req = 1'b1; man_op = 2'b11;
      step();
      man_req = 1'b0;
      check_val("s5 dec_on", 32'(counter_on), 32'd1);
      check_val("s5 dec_up", 32'(count_up), 32'd0);
      check_val("s5 dec_wrap", 32'(pos), 32'd15);
      step();
      man_req = 1'b1; man_op = 2'b00;
      step();
      man_req = 1'b0;
      check_val("s5 nop_ack", 32'(man_ack), 32'd1);
      check_val("s5 nop_on", 32'(counter_on), 32'd0);
      check_val("s5 nop_load", 32'(load), 32'd0);
      step();

      // Reset mid-RUN, then a clean restart
      lo_bound = 4'd1; hi_bound = 4'd9; presc = 8'd3; bounce = 1'b0;
      start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < 6; i++) step();
      check_val("s6 busy_before", 32'(busy), 32'd1);
      reset = 1'b0;
      step();
      reset = 1'b1;
      check_val("s6 load", 32'(load), 32'd0);
      check_val("s6 counter_on", 32'(counter_on), 32'd0);
      check_val("s6 count_up", 32'(count_up), 32'd0);
      check_val("s6 busy", 32'(busy), 32'd0);
      check_val("s6 done", 32'(done), 32'd0);
      check_val("s6 pos", 32'(pos), 32'd0);
      check_val("s6 cnt_data", 32'(cnt_data), 32'd0);
      step();
      check_val("s6 stays_idle", 32'(busy), 32'd0);
      start = 1'b1;
      step();
      start = 1'b0;
      check_val("s6 reload", 32'(load), 32'd1);
      check_val("s6 relo", 32'(cnt_data), 32'd1);
      check_val("s6 repos", 32'(pos), 32'd1);
      for (int i = 1; i <= 5; i++) begin
         step();
         check_val("s6 presc_strobe", 32'(counter_on), 32'(i == 5));
      end
      check_val("s6 first_step_pos", 32'(pos), 32'd2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Global time limit so the bench always terminates.
   initial begin
      #200000;
      $display("FAIL timeout: bench did not complete");
      $fatal(1, "timeout");
   end

endmodule
